// File: rtl/rot_pkg.sv
// Shared definitions for the rotate scheduler: datapath widths, direction
// encoding, request payload struct and the left-to-right amount conversion.
package rot_pkg;

  localparam int unsigned ROT_W     = 4;
  localparam int unsigned ROT_AMT_W = 2;

  localparam logic ROT_RIGHT = 1'b0;
  localparam logic ROT_LEFT  = 1'b1;

  typedef logic [ROT_W-1:0]     rot_data_t;
  typedef logic [ROT_AMT_W-1:0] rot_amt_t;

  // One requester's payload as seen after the grant mux.
  typedef struct packed {
    rot_data_t data;
    rot_amt_t  amt;
    logic      dir;
  } rot_req_t;

  // Left by a equals right by (4 - a) mod 4, i.e. the 2-bit negation of a.
  function automatic rot_amt_t rot_right_amt(input rot_amt_t amt, input logic dir);
    rot_amt_t res;
    res = amt;
    if (dir == ROT_LEFT) begin
      res = (~amt) + rot_amt_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/rotator4.sv
// Combinational 4-bit right rotator: out[k] = in[(k + amt) mod 4].
// Ports: in (operand), amt (right-rotate amount), out (rotated result).
module rotator4
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0]     in,
  input  logic [ROT_AMT_W-1:0] amt,
  output logic [ROT_W-1:0]     out
);

  always_comb begin
    out = in;
    case (amt)
      2'd1:    out = {in[0],   in[3:1]};
      2'd2:    out = {in[1:0], in[3:2]};
      2'd3:    out = {in[2:0], in[3]};
      default: out = in;
    endcase
  end

endmodule

// File: rtl/rotate_scheduler.sv
// Shares one 4-bit rotator among NREQ requesters via a round-robin arbiter;
// results are held in a one-entry output register tagged with requester ID.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           per-requester handshake (req_ready is combinational)
//   req_data/req_amt/req_dir      packed per-requester operand, amount, direction
//   out_valid/out_ready           result handshake
//   out_data/out_id               registered result and producing requester
module rotate_scheduler
  import rot_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [ROT_W*NREQ-1:0]     req_data,
  input  logic [ROT_AMT_W*NREQ-1:0] req_amt,
  input  logic [NREQ-1:0]           req_dir,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROT_W-1:0]          out_data,
  output logic [ID_W-1:0]           out_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  rot_data_t       out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q, out_id_d;

  logic            can_load_c;
  logic            xfer_c;
  logic            gnt_found_c;
  logic [ID_W-1:0] gnt_id_c;
  logic [NREQ-1:0] grant_c;
  rot_req_t        sel_req_c;
  rot_amt_t        rot_amt_c;
  rot_data_t       rot_out_c;

  // base + off modulo NREQ; both operands are below NREQ so one subtract suffices.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return ID_W'(sum);
  endfunction

  // Round-robin search starting at ptr_q, first valid requester wins.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_id_c    = '0;
    grant_c     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_found_c && req_valid[wrap_idx(ptr_q, i)]) begin
        gnt_found_c = 1'b1;
        gnt_id_c    = wrap_idx(ptr_q, i);
      end
    end
    grant_c[gnt_id_c] = gnt_found_c;
  end

  // Grant mux feeding the single shared rotator.
  always_comb begin
    sel_req_c.data = req_data[ROT_W*gnt_id_c +: ROT_W];
    sel_req_c.amt  = req_amt[ROT_AMT_W*gnt_id_c +: ROT_AMT_W];
    sel_req_c.dir  = req_dir[gnt_id_c];
  end

  assign rot_amt_c = rot_right_amt(sel_req_c.amt, sel_req_c.dir);

  rotator4 u_rot (
    .in  (sel_req_c.data),
    .amt (rot_amt_c),
    .out (rot_out_c)
  );

  // Gated by rst_n so ready is low throughout reset.
  assign can_load_c = (~out_valid_q | out_ready) & rst_n;
  assign xfer_c     = can_load_c & gnt_found_c;
  assign req_ready  = can_load_c ? grant_c : '0;

  // Output register and pointer next-state.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_out_c;
      out_id_d    = gnt_id_c;
      ptr_d       = (gnt_id_c == ID_W'(NREQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Self-checking bench for rotate_scheduler with NREQ = 4.
module tb_rotate_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   rv;
  logic [NREQ-1:0]   rr;
  logic [4*NREQ-1:0] rd;
  logic [2*NREQ-1:0] ra;
  logic [NREQ-1:0]   rdir;
  logic              ov;
  logic              ordy;
  logic [3:0]        od;
  logic [ID_W-1:0]   oid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_valid;
  logic [3:0] m_data;
  int         m_id;
  int         m_ptr;

  rotate_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv),
    .req_ready (rr),
    .req_data  (rd),
    .req_amt   (ra),
    .req_dir   (rdir),
    .out_valid (ov),
    .out_ready (ordy),
    .out_data  (od),
    .out_id    (oid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Direct definition: right out[k]=in[(k+a)%4], left out[k]=in[(k-a)%4].
  function automatic logic [3:0] ref_rot(logic [3:0] d, int a, bit left);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      if (left) r[k] = d[(k - a + 4) % 4];
      else      r[k] = d[(k + a) % 4];
    end
    return r;
  endfunction

  function automatic int exp_grant();
    for (int i = 0; i < NREQ; i++) begin
      if (rv[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (rst_n && (!m_valid || ordy) && g >= 0) return NREQ'(1 << g);
    return '0;
  endfunction

  function automatic void model_reset();
    m_valid = 0;
    m_data  = 4'b0000;
    m_id    = 0;
    m_ptr   = 0;
  endfunction

  // Advance one clock and update the model from the inputs seen before the edge.
  task automatic step();
    int g;
    bit cl;
    cl = !m_valid || ordy;
    g  = exp_grant();
    @(posedge clk);
    #1;
    if (cl && g >= 0) begin
      m_valid = 1;
      m_data  = ref_rot(rd[4*g +: 4], int'(ra[2*g +: 2]), rdir[g]);
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rv    = 4'hF;
    ordy  = 1'b0;
    rd    = 16'(32'($urandom));
    ra    = 8'($urandom);
    rdir  = 4'($urandom);
    model_reset();
    #3;
    checks++; if (ov !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
    checks++; if (od !== 4'h0)   begin errors++; $display("FAIL reset_out_data: got %b expected 0000", od); end
    checks++; if (oid !== 2'd0)  begin errors++; $display("FAIL reset_out_id: got %0d expected 0", oid); end
    checks++; if (rr !== 4'h0)   begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", rr); end
    rv = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    rv   = 4'hF;
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd   = 16'(32'($urandom));
      ra   = 8'($urandom);
      rdir = 4'($urandom);
      #1;
      checks++; if (rr !== 4'(1 << seq[i])) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, rr, 4'(1 << seq[i])); end
      step();
      checks++; if (oid !== 2'(seq[i])) begin errors++; $display("FAIL rr_out_id%0d: got %0d expected %0d", i, oid, seq[i]); end
      checks++; if (od !== m_data) begin errors++; $display("FAIL rr_out_data%0d: got %b expected %b", i, od, m_data); end
    end
    rv = 4'b0100;
    step();
    rv = 4'b1010;
    #1;
    checks++; if (rr !== 4'b1000) begin errors++; $display("FAIL rr_after2_ready: got %b expected 1000", rr); end
    step();
    checks++; if (oid !== 2'd3) begin errors++; $display("FAIL rr_after2_id: got %0d expected 3", oid); end
  endtask

  task automatic test_rotation();
    logic [3:0] din[6] = '{4'b0001, 4'b0001, 4'b1011, 4'b1011, 4'b1010, 4'b0110};
    int         amt[6] = '{1, 1, 2, 2, 0, 0};
    bit         dir[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp[6] = '{4'b1000, 4'b0010, 4'b1110, 4'b1110, 4'b1010, 4'b0110};
    rv   = 4'h0;
    ordy = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      rv      = 4'b0001;
      rd      = 16'(32'($urandom));
      ra      = 8'($urandom);
      rdir    = 4'($urandom);
      rd[3:0] = din[i];
      ra[1:0] = 2'(amt[i]);
      rdir[0] = dir[i];
      #1;
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rot_pre_valid%0d: got %b expected 0", i, ov); end
      step();
      rv = 4'h0;
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL rot_valid%0d: got %b expected 1", i, ov); end
      checks++; if (od !== exp[i]) begin errors++; $display("FAIL rot_data%0d: got %b expected %b", i, od, exp[i]); end
      checks++; if (oid !== 2'd0) begin errors++; $display("FAIL rot_id%0d: got %0d expected 0", i, oid); end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held;
    rv   = 4'b0001;
    ordy = 1'b1;
    rd   = 16'(32'($urandom));
    ra   = 8'($urandom);
    rdir = 4'($urandom);
    held = ref_rot(rd[3:0], int'(ra[1:0]), rdir[0]);
    step();
    ordy = 1'b0;
    rv   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      rd   = 16'(32'($urandom));
      ra   = 8'($urandom);
      rdir = 4'($urandom);
      #1;
      checks++; if (rr !== 4'h0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0000", i, rr); end
      checks++; if (ov !== 1'b1 || od !== held || oid !== 2'd0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%b id=%0d expected v=1 d=%b id=0", i, ov, od, oid, held);
      end
      step();
    end
    ordy = 1'b1;
    #1;
    checks++; if (rr !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", rr); end
    step();
    checks++; if (ov !== 1'b1 || oid !== 2'd1 || od !== ref_rot(rd[7:4], int'(ra[3:2]), rdir[1])) begin
      errors++; $display("FAIL bp_release_load: got v=%b d=%b id=%0d expected v=1 d=%b id=1", ov, od, oid, ref_rot(rd[7:4], int'(ra[3:2]), rdir[1]));
    end
  endtask

  task automatic test_throughput();
    logic [3:0] expq[$];
    logic [3:0] e;
    rv   = 4'b0001;
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd   = 16'(32'($urandom));
      ra   = 8'($urandom);
      rdir = 4'($urandom);
      expq.push_back(ref_rot(rd[3:0], int'(ra[1:0]), rdir[0]));
      step();
      e = expq.pop_front();
      checks++; if (ov !== 1'b1 || od !== e || oid !== 2'd0) begin
        errors++; $display("FAIL tput%0d: got v=%b d=%b id=%0d expected v=1 d=%b id=0", i, ov, od, oid, e);
      end
    end
  endtask

  task automatic test_idle();
    logic [3:0] last;
    last = od;
    rv   = 4'h0;
    ordy = 1'b1;
    step();
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", ov); end
    checks++; if (od !== last) begin errors++; $display("FAIL idle_data_hold: got %b expected %b", od, last); end
    step();
    rv = 4'hF;
    #1;
    checks++; if (rr !== 4'b0010) begin errors++; $display("FAIL idle_ptr_ready: got %b expected 0010", rr); end
    step();
    checks++; if (oid !== 2'd1) begin errors++; $display("FAIL idle_ptr_id: got %0d expected 1", oid); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] er;
    for (int i = 0; i < 300; i++) begin
      rv   = 4'($urandom);
      rd   = 16'(32'($urandom));
      ra   = 8'($urandom);
      rdir = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready();
      checks++; if (rr !== er) begin errors++; $display("FAIL rand_ready%0d: got %b expected %b", i, rr, er); end
      step();
      checks++; if (ov !== m_valid) begin errors++; $display("FAIL rand_valid%0d: got %b expected %b", i, ov, m_valid); end
      if (m_valid) begin
        checks++; if (od !== m_data || oid !== 2'(m_id)) begin
          errors++; $display("FAIL rand_result%0d: got d=%b id=%0d expected d=%b id=%0d", i, od, oid, m_data, m_id);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    rv   = 4'b0100;
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    rv   = 4'hF;
    #2;
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", ov); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (ov !== 1'b0)  begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", ov); end
    checks++; if (od !== 4'h0)  begin errors++; $display("FAIL mid_reset_data: got %b expected 0000", od); end
    checks++; if (oid !== 2'd0) begin errors++; $display("FAIL mid_reset_id: got %0d expected 0", oid); end
    checks++; if (rr !== 4'h0)  begin errors++; $display("FAIL mid_reset_ready: got %b expected 0000", rr); end
    rv = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    rv    = 4'hF;
    ordy  = 1'b1;
    #1;
    checks++; if (rr !== 4'b0001) begin errors++; $display("FAIL mid_after_ready: got %b expected 0001", rr); end
    step();
    checks++; if (ov !== 1'b1 || oid !== 2'd0) begin errors++; $display("FAIL mid_after_id: got v=%b id=%0d expected v=1 id=0", ov, oid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rotation();
    test_backpressure();
    test_throughput();
    test_idle();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotate_scheduler.md
# rotate_scheduler

Shares a single 4-bit rotate datapath between NREQ requesters. Each requester presents a 4-bit operand, a 2-bit rotate amount and a direction over a valid/ready handshake. A round-robin arbiter grants one request per cycle. The rotated result is held in a one-entry output register, tagged with the requester ID, until a downstream valid/ready consumer takes it.

## Interface
- NREQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NREQ), width of the requester ID tag.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; a request transfers when valid&ready.
- req_data  in  4*NREQ  operands; requester r uses bits [4r+3:4r].
- req_amt  in  2*NREQ  rotate amounts; requester r uses bits [2r+1:2r].
- req_dir  in  NREQ  direction per requester: 0 = rotate right, 1 = rotate left.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  4  rotated result.
- out_id  out  ID_W  index of the requester that produced out_data.

## Operation
- Rotate right by a: out[k] = in[(k+a) mod 4].
- Rotate left by a: out[k] = in[(k−a) mod 4]. This equals rotate right by (4−a) mod 4.
- a = 0 passes the operand through unchanged in either direction.
- The amount is 2 bits and wraps naturally, so no amount is illegal.
- can_load = ~out_valid | out_ready.
- Arbiter (combinational):
  - Round-robin priority pointer ptr, ID_W bits.
  - Search starts at ptr and proceeds upward, wrapping modulo NREQ.
  - The first asserted req_valid wins.
- req_ready[r] = can_load & grant[r].
  - At most one req_ready bit is high per cycle.
  - req_ready is all-zero when no request is valid or can_load = 0.
- On a transfer from requester g:
  - out_data ← rotate(req_data[g], req_amt[g], req_dir[g]).
  - out_id ← g.
  - out_valid ← 1.
  - ptr ← (g+1) mod NREQ.
- No transfer, but out_valid & out_ready: out_valid ← 0. out_data and out_id hold their last values.
- Simultaneous consume and accept in the same cycle: out_valid stays 1 and the register loads the new result. This gives full throughput of 1 result per cycle.
- ptr changes only on a transfer. An idle cycle or a stalled cycle leaves ptr unchanged.
- Requester-side rules:
  - A requester must hold valid, data, amt and dir stable until it sees ready.
  - The block does not rely on this for correctness; it samples only in the transfer cycle.
- out_data, out_id and out_valid are stable while out_valid & ~out_ready.
- NREQ not a power of two: ptr wraps from NREQ−1 to 0. Values ≥ NREQ are unreachable.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 4'b0000, out_id = 0, ptr = 0.
- req_ready is combinational, so it is 0 while in reset.
- Deassertion of rst_n is synchronized externally. The first transfer can occur on the first rising edge after release.
- Latency: request transfer at edge N gives out_valid = 1 with the result after edge N.
- req_ready depends combinationally on req_valid, ptr, out_valid and out_ready.
- There is no combinational path from any request input to out_valid, out_data or out_id.
- Reset mid-operation: a held result is discarded and ptr returns to 0. In-flight requesters see ready drop immediately.
- Fairness: a continuously valid requester is granted within NREQ transfers.

## Structure
- Package rot_pkg holds the shared definitions:
  - ROT_W = 4 and ROT_AMT_W = 2.
  - Direction constants ROT_RIGHT = 1'b0 and ROT_LEFT = 1'b1.
  - Function rot_right_amt(amt, dir), which returns the equivalent right-rotate amount.
- One combinational sub-module, rotator4 (in[3:0], amt[1:0], out[3:0]): right rotate only.
  - rotate_scheduler converts left rotates to right before driving it.
  - It is instantiated once, fed by the granted request's mux output.
- Arbiter, pointer and output register live in rotate_scheduler. No separate arbiter module.

## Test plan
- Reset values: assert rst_n low mid-stream while out_valid = 1. Check out_valid = 0, out_data = 0, out_id = 0, req_ready = 0 immediately (asynchronous, no clock edge needed).
- Rotation cases, one requester, out_ready = 1:
  - data 4'b0001, amt 1, right → out_data 4'b1000.
  - Same data, left → 4'b0010.
  - 4'b1011, amt 2, either direction → 4'b1110.
  - amt 0 → unchanged.
  - Result appears exactly one cycle after the transfer.
- Round-robin, NREQ = 4, all requesters valid, out_ready = 1:
  - Grants go 0, 1, 2, 3, 0.
  - out_id follows the same sequence, one per cycle.
  - After a transfer from requester 2, then only requesters 1 and 3 valid → 3 is granted first.
- Back-pressure: out_ready = 0 with a result held.
  - req_ready is all-zero and out_data/out_id are stable for 5 cycles.
  - Raise out_ready → the next result loads in the same cycle, no bubble.
- Full throughput: requester 0 streams 8 operands with out_ready held at 1 → 8 results on 8 consecutive cycles, in order.
- Idle: no req_valid and out_ready = 1 → out_valid drops one cycle after the last consume, and ptr is unchanged (checked by the next grant order).
